// File: rtl/mp_add_sequencer_pkg.sv
// Shared definitions for the 16-bit arithmetic unit and its multi-precision add sequencer.
package mp_add_sequencer_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FLAG = 2'd2,
    ST_DONE = 2'd3
  } seqState_t;

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Request/result handshake plus the word-wide link to the arithmetic unit.
interface mp_add_sequencer_if #(parameter int WORDS = 4);
  import mp_add_sequencer_pkg::*;

  logic                      iStart;
  logic                      oReady;
  logic [WORD_W*WORDS-1:0]   iOperandA;
  logic [WORD_W*WORDS-1:0]   iOperandB;
  logic                      oValid;
  logic                      iReady;
  logic [WORD_W*WORDS-1:0]   oResult;
  logic                      oCarry;
  logic                      oZero;
  logic [WORD_W-1:0]         oAluPortA;
  logic [WORD_W-1:0]         oAluPortB;
  logic [1:0]                oAluOpcode;
  logic [WORD_W-1:0]         iAluAccumulator;
  logic                      iAluCarry;

  // Sequencer side.
  modport slave (
    input  iStart, iOperandA, iOperandB, iReady, iAluAccumulator, iAluCarry,
    output oReady, oValid, oResult, oCarry, oZero, oAluPortA, oAluPortB, oAluOpcode
  );

  // Requester / consumer / arithmetic-unit side.
  modport master (
    output iStart, iOperandA, iOperandB, iReady, iAluAccumulator, iAluCarry,
    input  oReady, oValid, oResult, oCarry, oZero, oAluPortA, oAluPortB, oAluOpcode
  );

endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: walks the operands through the 16-bit arithmetic unit
// one word per cycle (ADD then ADC), assembling the wide sum, carry and zero flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; unit held on SUB 0-0 so its carry stays 0
// RUN   | word k on the unit's ports; accumulator captured into word k
// FLAG  | unit's carry flag now holds the top carry; latch carry/zero
// DONE  | result valid and frozen until the consumer takes it
module mp_add_sequencer
  import mp_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                iClock,
  input  logic                iReset,
  mp_add_sequencer_if.slave   bus
);

  localparam int W  = WORD_W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  seqState_t       state;
  seqState_t       stateNext;
  logic [KW-1:0]   k;
  logic            lastWord;
  logic [W-1:0]    opA;
  logic [W-1:0]    opB;
  logic [W-1:0]    result;
  logic            carry;
  logic            zero;

  assign lastWord    = (k == KW'(WORDS - 1));
  assign bus.oResult = result;
  assign bus.oCarry  = carry;
  assign bus.oZero   = zero;

  // State register.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: if (bus.iStart) stateNext = ST_RUN;
      ST_RUN:  if (lastWord)   stateNext = ST_FLAG;
      ST_FLAG:                 stateNext = ST_DONE;
      ST_DONE: if (bus.iReady) stateNext = ST_IDLE;
      default:                 stateNext = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state and the word counter only.
  always_comb begin
    bus.oReady     = (state == ST_IDLE);
    bus.oValid     = (state == ST_DONE);
    bus.oAluOpcode = OP_SUB;
    bus.oAluPortA  = '0;
    bus.oAluPortB  = '0;
    if (state == ST_RUN) begin
      bus.oAluOpcode = (k == '0) ? OP_ADD : OP_ADC;
      for (int i = 0; i < WORDS; i++) begin
        if (k == KW'(i)) begin
          bus.oAluPortA = opA[WORD_W*i +: WORD_W];
          bus.oAluPortB = opB[WORD_W*i +: WORD_W];
        end
      end
    end
  end

  // Operand capture, word counter, result assembly and flag latching.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      opA    <= '0;
      opB    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      k      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.iStart) begin
            opA <= bus.iOperandA;
            opB <= bus.iOperandB;
            k   <= '0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) result[WORD_W*i +: WORD_W] <= bus.iAluAccumulator;
          end
          k <= k + KW'(1);
        end
        ST_FLAG: begin
          carry <= bus.iAluCarry;
          zero  <= (result == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Randomized self-checking bench: a 4-word and a 1-word sequencer, each driving
// a behavioural 16-bit arithmetic unit, checked against wide-integer addition.
module tb_mp_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit curSel = 1'b0;   // 0: four-word instance, 1: one-word instance

  mp_add_sequencer_if #(.WORDS(4)) bus4 ();
  mp_add_sequencer_if #(.WORDS(1)) bus1 ();

  mp_add_sequencer #(.WORDS(4)) dut4 (.iClock(clk), .iReset(rst), .bus(bus4.slave));
  mp_add_sequencer #(.WORDS(1)) dut1 (.iClock(clk), .iReset(rst), .bus(bus1.slave));

  // Behavioural arithmetic units: combinational accumulator, registered carry.
  logic [16:0] aluSum4, aluSum1;
  logic        aluC4, aluC1;

  always_comb begin
    case (bus4.oAluOpcode)
      2'b01:   aluSum4 = {1'b0, bus4.oAluPortA} + {1'b0, bus4.oAluPortB};
      2'b10:   aluSum4 = {1'b0, bus4.oAluPortA} + {1'b0, bus4.oAluPortB} + {16'b0, aluC4};
      2'b11:   aluSum4 = {1'b0, bus4.oAluPortA} - {1'b0, bus4.oAluPortB};
      default: aluSum4 = '0;
    endcase
  end
  always_comb begin
    case (bus1.oAluOpcode)
      2'b01:   aluSum1 = {1'b0, bus1.oAluPortA} + {1'b0, bus1.oAluPortB};
      2'b10:   aluSum1 = {1'b0, bus1.oAluPortA} + {1'b0, bus1.oAluPortB} + {16'b0, aluC1};
      2'b11:   aluSum1 = {1'b0, bus1.oAluPortA} - {1'b0, bus1.oAluPortB};
      default: aluSum1 = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluC4 <= 1'b0;
      aluC1 <= 1'b0;
    end else begin
      if (bus4.oAluOpcode != 2'b00) aluC4 <= aluSum4[16];
      if (bus1.oAluOpcode != 2'b00) aluC1 <= aluSum1[16];
    end
  end
  assign bus4.iAluAccumulator = aluSum4[15:0];
  assign bus4.iAluCarry       = aluC4;
  assign bus1.iAluAccumulator = aluSum1[15:0];
  assign bus1.iAluCarry       = aluC1;

  // Observation mux over the selected instance.
  logic        obsValid, obsReady, obsCarry, obsZero;
  logic [63:0] obsResult;
  logic [1:0]  obsOpcode;
  logic [15:0] obsPortA, obsPortB;
  always_comb begin
    obsValid  = curSel ? bus1.oValid     : bus4.oValid;
    obsReady  = curSel ? bus1.oReady     : bus4.oReady;
    obsCarry  = curSel ? bus1.oCarry     : bus4.oCarry;
    obsZero   = curSel ? bus1.oZero      : bus4.oZero;
    obsResult = curSel ? {48'b0, bus1.oResult} : bus4.oResult;
    obsOpcode = curSel ? bus1.oAluOpcode : bus4.oAluOpcode;
    obsPortA  = curSel ? bus1.oAluPortA  : bus4.oAluPortA;
    obsPortB  = curSel ? bus1.oAluPortB  : bus4.oAluPortB;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic setStart(input logic v, input logic [63:0] a, input logic [63:0] b);
    if (curSel) begin
      bus1.iStart = v; bus1.iOperandA = a[15:0]; bus1.iOperandB = b[15:0];
    end else begin
      bus4.iStart = v; bus4.iOperandA = a;       bus4.iOperandB = b;
    end
  endtask

  task automatic setReady(input logic v);
    if (curSel) bus1.iReady = v;
    else        bus4.iReady = v;
  endtask

  // One request: checks the word-by-word unit traffic, latency, result, flags,
  // backpressure stability for holdCycles, and the result handshake.
  // Entered and left just after a falling edge.
  task automatic runOp(input logic [63:0] a, input logic [63:0] b, input int holdCycles);
    int          words;
    int          cyc;
    logic [63:0] mask, expRes, am, bm;
    logic [64:0] s;
    logic        expC;
    words  = curSel ? 1 : 4;
    mask   = curSel ? 64'hFFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    am     = a & mask;
    bm     = b & mask;
    s      = {1'b0, am} + {1'b0, bm};
    expRes = s[63:0] & mask;
    expC   = curSel ? s[16] : s[64];

    checkVal("ready before start", {63'b0, obsReady}, 64'd1);
    setStart(1'b1, a, b);
    @(posedge clk);
    #1 setStart(1'b0, 64'h0, 64'h0);
    @(negedge clk);
    for (int i = 0; i < words; i++) begin
      checkVal($sformatf("opcode w%0d", i), {62'b0, obsOpcode}, (i == 0) ? 64'd1 : 64'd2);
      checkVal($sformatf("portA w%0d", i), {48'b0, obsPortA}, (am >> (16*i)) & 64'hFFFF);
      checkVal($sformatf("portB w%0d", i), {48'b0, obsPortB}, (bm >> (16*i)) & 64'hFFFF);
      @(negedge clk);
    end
    checkVal("opcode after run", {62'b0, obsOpcode}, 64'd3);
    cyc = words;
    while (!obsValid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!obsValid) begin
      checkVal("valid timeout", 64'd0, 64'd1);
      return;
    end
    checkVal("latency", cyc, words + 1);
    checkVal("result", obsResult, expRes);
    checkVal("carry", {63'b0, obsCarry}, {63'b0, expC});
    checkVal("zero", {63'b0, obsZero}, {63'b0, (expRes == 64'h0)});
    checkVal("ready in done", {63'b0, obsReady}, 64'd0);

    for (int h = 0; h < holdCycles; h++) begin
      setStart(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      checkVal("hold valid", {63'b0, obsValid}, 64'd1);
      checkVal("hold result", obsResult, expRes);
      checkVal("hold carry", {63'b0, obsCarry}, {63'b0, expC});
      checkVal("hold ready", {63'b0, obsReady}, 64'd0);
    end
    setStart(1'b0, 64'h0, 64'h0);
    setReady(1'b1);
    @(negedge clk);
    setReady(1'b0);
    checkVal("valid after accept", {63'b0, obsValid}, 64'd0);
    checkVal("ready after accept", {63'b0, obsReady}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus4.iStart = 1'b0; bus4.iReady = 1'b0; bus4.iOperandA = '0; bus4.iOperandB = '0;
    bus1.iStart = 1'b0; bus1.iReady = 1'b0; bus1.iOperandA = '0; bus1.iOperandB = '0;
    @(negedge clk);
    @(negedge clk);
    checkVal("rst ready4",  {63'b0, bus4.oReady}, 64'd1);
    checkVal("rst valid4",  {63'b0, bus4.oValid}, 64'd0);
    checkVal("rst result4", bus4.oResult, 64'd0);
    checkVal("rst carry4",  {63'b0, bus4.oCarry}, 64'd0);
    checkVal("rst zero4",   {63'b0, bus4.oZero}, 64'd0);
    checkVal("rst opcode4", {62'b0, bus4.oAluOpcode}, 64'd3);
    checkVal("rst portA4",  {48'b0, bus4.oAluPortA}, 64'd0);
    checkVal("rst ready1",  {63'b0, bus1.oReady}, 64'd1);
    checkVal("rst opcode1", {62'b0, bus1.oAluOpcode}, 64'd3);
    rst = 1'b0;
    @(negedge clk);

    curSel = 1'b0;
    runOp(64'h0000_0000_0000_FFFF, 64'h1, 0);
    runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    runOp(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0);
    runOp(64'hDEAD_BEEF_CAFE_F00D, 64'h8000_7FFF_0001_FFFF, 6);

    // Reset while word 1 is on the unit's ports.
    setStart(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 setStart(1'b0, 64'h0, 64'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkVal("midrst ready",  {63'b0, bus4.oReady}, 64'd1);
    checkVal("midrst valid",  {63'b0, bus4.oValid}, 64'd0);
    checkVal("midrst opcode", {62'b0, bus4.oAluOpcode}, 64'd3);
    checkVal("midrst portA",  {48'b0, bus4.oAluPortA}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp(64'h5, 64'h3, 0);

    for (int n = 0; n < 12; n++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? ~a + 64'($urandom_range(0, 1)) : {$urandom, $urandom};
      runOp(a, b, $urandom_range(0, 3));
    end

    curSel = 1'b1;
    runOp(64'hFFFF, 64'h0001, 0);
    runOp(64'h7FFF, 64'h0001, 2);
    for (int n = 0; n < 6; n++) begin
      runOp({48'b0, 16'($urandom)}, {48'b0, 16'($urandom)}, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_add_sequencer.md
# mp_add_sequencer

Multi-precision add sequencer that drives the 16-bit arithmetic unit as its initiator. It accepts two WORDS×16-bit operands through a ready/valid handshake. It then issues one ADD followed by WORDS−1 ADC operations to the arithmetic unit, one 16-bit word per cycle, least-significant word first. It assembles the full-width sum with final carry and whole-result zero flag and holds them until the consumer accepts them.

## Interface
- WORDS, default 4: number of 16-bit words per operand; legal range 1–16.
- iClock  in  1  rising-edge clock shared with the arithmetic unit.
- iReset  in  1  asynchronous, active-high reset; same net as the arithmetic unit's reset.
- iStart  in  1  request valid; operands are accepted when iStart & oReady.
- oReady  out  1  sequencer idle and able to accept a request.
- iOperandA  in  16*WORDS  augend; word k is bits [16k+15:16k].
- iOperandB  in  16*WORDS  addend.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts the result when oValid & iReady.
- oResult  out  16*WORDS  sum modulo 2^(16*WORDS).
- oCarry  out  1  carry out of the most-significant word.
- oZero  out  1  1 when oResult is all zeros.
- oAluPortA  out  16  word to the arithmetic unit's port A.
- oAluPortB  out  16  word to the arithmetic unit's port B.
- oAluOpcode  out  2  opcode to the arithmetic unit.
- iAluAccumulator  in  16  combinational sum from the arithmetic unit.
- iAluCarry  in  1  the arithmetic unit's registered carry flag.

## Operation
- **States:** IDLE, RUN, FLAG, DONE.
- **IDLE:** oReady=1. If iStart=1, latch both operands, clear the word counter k to 0 and go to RUN.
- **RUN:**
  - Drive oAluPortA/oAluPortB with word k of the latched operands.
  - oAluOpcode = ADD (01) when k=0, ADC (10) otherwise.
  - On each edge, write iAluAccumulator into result word k. The arithmetic unit's carry flop captures that word's carry on the same edge, and the next ADC consumes it.
  - k increments each cycle. After the edge with k=WORDS−1, go to FLAG.
- **FLAG:** iAluCarry holds the carry out of the last word. Latch it into oCarry, latch oZero from the assembled result, set oValid and go to DONE.
- **DONE:** oValid=1; oResult, oCarry and oZero are held stable. When iReady=1, clear oValid and go to IDLE.
- **oAluOpcode outside RUN:** SUB (11). This keeps the arithmetic unit's carry flop cleared while idle, so no stale carry enters a later operation.
- **oAluPortA/oAluPortB outside RUN:** 0.
- **Handshake rules:**
  - iStart is ignored outside IDLE.
  - oValid never drops without iReady.
  - A new request is accepted no earlier than the cycle after the result handshake.
- **Width rule:** overflow past 16*WORDS bits appears only in oCarry. oZero reflects oResult only, not oCarry.
- **Reset** (any time, including mid-RUN), applied immediately:
  - state IDLE, oReady=1, oValid=0;
  - oResult=0, oCarry=0, oZero=0;
  - oAluOpcode=11, oAluPortA/oAluPortB=0;
  - the partial result is discarded.

## Timing
- Request accepted at edge E0. RUN occupies edges E1..E(WORDS), FLAG is edge E(WORDS+1), and oValid is high in the following cycle: latency WORDS+1 cycles.
- Minimum request-to-request spacing is WORDS+3 cycles (zero-wait consumer).
- The arithmetic unit path is combinational within one cycle: the sequencer word registers → the unit's adder → the result register. No added pipeline stage.
- oReady is decoded from state (registered state only); no combinational path from iStart to any output.

## Structure
- **Shared package** (the arithmetic-unit package):
  - opcode constants OP_ADD=2'b01, OP_ADC=2'b10, OP_SUB=2'b11;
  - word width 16;
  - state enumeration.
- **Sub-modules:** none required. The counter, operand/result registers and FSM stay in one module.
- **Integration:** the integration top instantiates the sequencer next to the existing arithmetic unit and ties the reset nets together.

## Test plan
- **Cross-word carry:** WORDS=4, A=0x0000_0000_0000_FFFF, B=0x1 → oResult=0x0000_0000_0001_0000, oCarry=0, oZero=0; oAluOpcode sequence 01,10,10,10.
- **Full overflow:** A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → oResult=0, oCarry=1, oZero=1.
- **No carries:** A=0x1234_5678_9ABC_DEF0, B=0x1111_1111_1111_1111 → oResult=0x2345_6789_ABCD_F001, oCarry=0. oValid must rise exactly 5 cycles after the start edge.
- **Backpressure:** hold iReady=0 for 6 cycles in DONE → oValid, oResult and oCarry stay stable; iStart pulses are ignored and oReady stays 0. Result accepted on the first iReady=1.
- **Reset mid-operation:** assert iReset during RUN with k=1 → immediately IDLE, oReady=1, oValid=0, oAluOpcode=11. The next request (A=0x5, B=0x3) yields 0x8 with no stale carry.
- **WORDS=1:** A=0xFFFF, B=0x0001 → oResult=0x0000, oCarry=1, oZero=1, latency 2 cycles.
